// File: rtl/mem_pkg.sv
// Shared types for the data memory: request parameters, access sizes and the
// data_mem controller state, plus the byte-lane mask helper.
package mem_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_access_size_t;

  typedef struct packed {
    logic             read_unsigned;
    mem_access_size_t access_size;
    mem_op_t          op;
  } mem_params_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } data_mem_state_t;

  // Wide enough to hold READ_LATENCY-1 for latencies up to 8.
  localparam int unsigned LAT_CNT_W = 3;

  function automatic logic [3:0] lane_mask(mem_access_size_t size, logic [1:0] lane);
    case (size)
      MEM_BYTE: lane_mask = 4'b0001 << lane;
      MEM_HALF: lane_mask = 4'b0011 << lane;
      MEM_WORD: lane_mask = 4'b1111;
      default:  lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed lane(s) out of a storage
// word and zero- or sign-extends the result to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0]      word_i,
  input  logic [1:0]       lane_i,
  input  mem_access_size_t size_i,
  input  logic             unsigned_i,
  output logic [31:0]      data_o
);

  logic [15:0] shifted;

  always_comb begin
    shifted = 16'(word_i >> {lane_i, 3'b000});
    data_o  = '0;
    case (size_i)
      MEM_BYTE: data_o = unsigned_i ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: data_o = unsigned_i ? {16'b0, shifted}
                                    : {{16{shifted[15]}}, shifted};
      MEM_WORD: data_o = word_i;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory with a single outstanding request, fixed read
// latency, misalignment/range faults and a reset-time word preload port.
module data_mem
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  mem_params_t req_params,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  input  logic        setup_write,
  input  logic [31:0] setup_address,
  input  logic [31:0] setup_data_in
);

  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned AW    = $clog2(WORDS);

  logic [3:0][7:0] mem_q [WORDS];

  data_mem_state_t       state_q;
  logic [LAT_CNT_W-1:0]  cnt_q;
  logic                  resp_valid_q;
  logic                  resp_fault_q;
  logic [31:0]           resp_rdata_q;

  logic [AW-1:0] req_word;
  logic [AW-1:0] setup_word;
  logic          accept;
  logic          is_store;
  logic          fault;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_lanes;
  logic [31:0]   load_aligned;
  logic [31:0]   resp_rdata_d;
  logic          unused_setup_bits;

  assign req_word   = req_addr[AW+1:2];
  assign setup_word = setup_address[AW+1:2];
  assign unused_setup_bits = ^{setup_address[31:AW+2], setup_address[1:0]};

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_ready && req_valid;
  assign is_store  = (req_params.op == MEM_STORE);

  always_comb begin
    fault = 1'b0;
    case (req_params.access_size)
      MEM_HALF: fault = req_addr[0];
      MEM_WORD: fault = (req_addr[1:0] != 2'b00);
      MEM_RSVD: fault = 1'b1;
      default:  fault = 1'b0;
    endcase
    if (req_addr >= 32'(MEM_BYTES)) fault = 1'b1;
  end

  // Store data replicated so each enabled lane already sees its own byte.
  always_comb begin
    wr_mask  = lane_mask(req_params.access_size, req_addr[1:0]);
    wr_lanes = req_wdata;
    case (req_params.access_size)
      MEM_BYTE: wr_lanes = {4{req_wdata[7:0]}};
      MEM_HALF: wr_lanes = {2{req_wdata[15:0]}};
      default:  wr_lanes = req_wdata;
    endcase
  end

  mem_load_align u_align (
    .word_i     (mem_q[req_word]),
    .lane_i     (req_addr[1:0]),
    .size_i     (req_params.access_size),
    .unsigned_i (req_params.read_unsigned),
    .data_o     (load_aligned)
  );

  assign resp_rdata_d = (fault || is_store) ? 32'h0 : load_aligned;

  // Storage is never cleared; reset only opens the preload path.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (setup_write) mem_q[setup_word] <= setup_data_in;
    end else if (accept && is_store && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem_q[req_word][i] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cnt_q        <= LAT_CNT_W'(READ_LATENCY - 1);
            resp_fault_q <= fault;
            resp_rdata_q <= resp_rdata_d;
            if (READ_LATENCY == 1) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a latency-1 instance for function and faults,
// a latency-3 instance for back-pressure and mid-transaction reset.
module tb_data_mem;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        setup_write;
  logic [31:0] setup_address;
  logic [31:0] setup_data_in;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_fault;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  mem_params_t req_params;

  logic        req_valid3, req_ready3, resp_valid3, resp_ready3, resp_fault3;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3;
  mem_params_t req_params3;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  data_mem #(.MEM_BYTES(65536), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_params(req_params),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .setup_write(setup_write), .setup_address(setup_address),
    .setup_data_in(setup_data_in)
  );

  data_mem #(.MEM_BYTES(1024), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .req_params(req_params3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_rdata(resp_rdata3), .resp_fault(resp_fault3),
    .setup_write(setup_write), .setup_address(setup_address),
    .setup_data_in(setup_data_in)
  );

  function automatic mem_params_t mp(logic ru, mem_access_size_t s, mem_op_t o);
    mem_params_t p;
    p.read_unsigned = ru;
    p.access_size   = s;
    p.op            = o;
    return p;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the latency-1 instance; response expected one cycle later.
  task automatic txn(input logic [31:0] a, input logic [31:0] w, input mem_params_t p,
                     input logic [31:0] exp_d, input logic exp_f, input string tag);
    int n;
    @(negedge clock);
    chk(req_ready, 1, {tag, "_ready"});
    req_valid = 1'b1; req_addr = a; req_wdata = w; req_params = p;
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    @(negedge clock);
    while (!resp_valid && n < 10) begin
      n++;
      @(negedge clock);
    end
    chk(n, 0, {tag, "_latency"});
    chk(resp_valid, 1, {tag, "_valid"});
    chk(resp_rdata, exp_d, {tag, "_rdata"});
    chk(resp_fault, exp_f, {tag, "_fault"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; setup_write = 1'b0; setup_address = '0; setup_data_in = '0;
    req_valid = 1'b1; req_addr = 32'h0; req_wdata = '0;
    req_params = mp(1'b0, MEM_WORD, MEM_LOAD); resp_ready = 1'b1;
    req_valid3 = 1'b0; req_addr3 = '0; req_wdata3 = '0;
    req_params3 = mp(1'b0, MEM_WORD, MEM_LOAD); resp_ready3 = 1'b0;

    // Preload under reset while a request is held (must be ignored).
    @(negedge clock); setup_write = 1'b1; setup_address = 32'h0; setup_data_in = 32'h8070_F0A5;
    @(negedge clock); setup_address = 32'h4;  setup_data_in = 32'h0;
    @(negedge clock); setup_address = 32'h0B; setup_data_in = 32'h1122_3344;
    @(negedge clock); setup_write = 1'b0;
    chk(req_ready, 0, "rst_ready");
    chk(resp_valid, 0, "rst_valid");
    chk(resp_fault, 0, "rst_fault");
    chk(resp_rdata, 0, "rst_rdata");
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk(resp_valid, 0, "post_rst_valid");
    chk(req_ready, 1, "post_rst_ready");

    txn(32'h0, 32'h0, mp(1'b0, MEM_BYTE, MEM_LOAD), 32'hFFFF_FFA5, 1'b0, "lb_0");
    txn(32'h2, 32'h0, mp(1'b1, MEM_HALF, MEM_LOAD), 32'h0000_8070, 1'b0, "lhu_2");
    txn(32'h2, 32'h0, mp(1'b0, MEM_HALF, MEM_LOAD), 32'hFFFF_8070, 1'b0, "lh_2");
    txn(32'h1, 32'h0, mp(1'b1, MEM_BYTE, MEM_LOAD), 32'h0000_00F0, 1'b0, "lbu_1");
    txn(32'h8, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h1122_3344, 1'b0, "lw_preload_b");
    txn(32'h5, 32'hFFFF_FF12, mp(1'b0, MEM_BYTE, MEM_STORE), 32'h0, 1'b0, "sb_5");
    txn(32'h4, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h0000_1200, 1'b0, "lw_4");
    txn(32'h6, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h0, 1'b1, "lw_mis_6");
    txn(32'h3, 32'h0000_BEEF, mp(1'b0, MEM_HALF, MEM_STORE), 32'h0, 1'b1, "sh_mis_3");
    txn(32'h0, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h8070_F0A5, 1'b0, "lw_0_unchanged");
    txn(32'h4, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h0000_1200, 1'b0, "lw_4_unchanged");
    txn(32'h0001_0000, 32'h0, mp(1'b0, MEM_BYTE, MEM_LOAD), 32'h0, 1'b1, "lb_range");
    txn(32'h0, 32'h0, mp(1'b0, MEM_RSVD, MEM_LOAD), 32'h0, 1'b1, "rsvd");
    txn(32'hA, 32'h0000_ABCD, mp(1'b0, MEM_HALF, MEM_STORE), 32'h0, 1'b0, "sh_a");
    txn(32'h8, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'hABCD_3344, 1'b0, "lw_8");
    txn(32'h4, 32'hCAFE_BABE, mp(1'b0, MEM_WORD, MEM_STORE), 32'h0, 1'b0, "sw_4");
    txn(32'h6, 32'h0, mp(1'b0, MEM_HALF, MEM_LOAD), 32'hFFFF_CAFE, 1'b0, "lh_6");

    // Preload strobe outside reset must not touch storage.
    @(negedge clock); setup_write = 1'b1; setup_address = 32'h0; setup_data_in = 32'h0;
    @(negedge clock); setup_write = 1'b0;
    txn(32'h0, 32'h0, mp(1'b0, MEM_WORD, MEM_LOAD), 32'h8070_F0A5, 1'b0, "setup_ignored");

    // Latency-3 instance with the consumer stalling.
    @(negedge clock);
    chk(req_ready3, 1, "l3_ready");
    req_valid3 = 1'b1; req_addr3 = 32'h8; req_params3 = mp(1'b0, MEM_WORD, MEM_LOAD);
    @(posedge clock);
    #1 req_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk(resp_valid3, 0, "l3_early_valid");
      chk(req_ready3, 0, "l3_wait_ready");
    end
    @(negedge clock);
    chk(resp_valid3, 1, "l3_valid_rise");
    chk(resp_rdata3, 32'h1122_3344, "l3_rdata");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk(resp_valid3, 1, "l3_hold_valid");
      chk(resp_rdata3, 32'h1122_3344, "l3_hold_rdata");
      chk(resp_fault3, 0, "l3_hold_fault");
      chk(req_ready3, 0, "l3_hold_ready");
    end
    resp_ready3 = 1'b1;
    @(posedge clock);
    #1 resp_ready3 = 1'b0;
    @(negedge clock);
    chk(resp_valid3, 0, "l3_done_valid");
    chk(req_ready3, 1, "l3_done_ready");

    // Reset while the latency-3 instance is waiting.
    req_valid3 = 1'b1; req_addr3 = 32'h0;
    @(posedge clock);
    #1 req_valid3 = 1'b0;
    @(negedge clock);
    chk(resp_valid3, 0, "rw_pre_valid");
    reset = 1'b1;
    @(negedge clock);
    chk(resp_valid3, 0, "rw_rst_valid");
    chk(req_ready3, 0, "rw_rst_ready");
    reset = 1'b0;
    @(negedge clock);
    chk(req_ready3, 1, "rw_release_ready");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk(resp_valid3, 0, "rw_no_resp");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
